// File: rtl/vga_pkg.sv
// Shared raster types and default 640x480@60 timing for the video output stage.
// Pure declarations; no logic, no latency.
package vga_pkg;

   typedef logic [10:0] coord_t;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int PIPE_LAT_DEF = 2;

   typedef struct packed {
      logic act;
      logic hs;
      logic vs;
   } raster_ctl_t;

   // Blanked with both syncs idle: the state the pins show before any real pixel arrives.
   localparam raster_ctl_t CTL_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of DEPTH stages; output is the input DEPTH enabled steps ago.
// Holds completely while en_i is low; reset loads every stage with RST_VAL.
module vga_delay_line #(
   parameter int               WIDTH   = 3,
   parameter int               DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else if (en_i) begin
         stage_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_raster_out.sv
// Raster master and VGA pin stage: drives pixelX/Y/startOfFrame and registers the mux colours onto the DAC.
// Pixel on pixelX/Y reaches the pins PIPE_LAT+1 pix_en steps later; pix_en low freezes every register.
module vga_raster_out
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       pix_en,
   input  logic [3:0] Red_level,
   input  logic [3:0] Green_level,
   input  logic [3:0] Blue_level,
   output coord_t     pixelX,
   output coord_t     pixelY,
   output logic       startOfFrame,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
   localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
   localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_total_chk
      $error("vga_raster_out: H_TOTAL/V_TOTAL do not fit 11-bit coordinates");
   end
   if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_lat_chk
      $error("vga_raster_out: PIPE_LAT must be within 1..8");
   end

   coord_t h_q, h_d, v_q, v_d;

   always_comb begin
      h_d = h_q + coord_t'(1);
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = '0;
         v_d = (v_q == V_LAST) ? '0 : v_q + coord_t'(1);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         h_q <= '0;
         v_q <= '0;
      end else if (pix_en) begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign pixelX = h_q;
   assign pixelY = v_q;

   // Gated by pix_en so the pulse stays one clk wide however slowly the raster steps.
   assign startOfFrame = pix_en && (h_q == H_LAST) && (v_q == V_LAST);

   raster_ctl_t ctl_raw, ctl_dly;

   always_comb begin
      ctl_raw.act = (h_q < H_VIS) && (v_q < V_VIS);
      ctl_raw.hs  = !((h_q >= HS_START) && (h_q < HS_END));
      ctl_raw.vs  = !((v_q >= VS_START) && (v_q < VS_END));
   end

   // Sync/blank wait here while the drawing units and mux turn the same coordinates into colour.
   vga_delay_line #(
      .WIDTH  ($bits(raster_ctl_t)),
      .DEPTH  (PIPE_LAT),
      .RST_VAL(CTL_IDLE)
   ) u_ctl_dly (
      .clk   (clk),
      .resetN(resetN),
      .en_i  (pix_en),
      .d_i   (ctl_raw),
      .q_o   (ctl_dly)
   );

   logic [3:0] r_q, g_q, b_q;
   logic       hs_q, vs_q, blank_n_q;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
      end else if (pix_en) begin
         r_q       <= ctl_dly.act ? Red_level   : 4'h0;
         g_q       <= ctl_dly.act ? Green_level : 4'h0;
         b_q       <= ctl_dly.act ? Blue_level  : 4'h0;
         hs_q      <= ctl_dly.hs;
         vs_q      <= ctl_dly.vs;
         blank_n_q <= ctl_dly.act;
      end
   end

   assign vga_r       = r_q;
   assign vga_g       = g_q;
   assign vga_b       = b_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;

endmodule

// File: tb/tb_vga_raster_out.sv
// Scoreboard bench for vga_raster_out on a shrunken raster: a pixel-walk model predicts coordinates,
// SOF and pin values, a mux model feeds colours back, and run-length monitors time the sync/blank pulses.
module tb_vga_raster_out;

   localparam int HA = 24, HF = 4, HSW = 6, HB = 6;
   localparam int VA = 14, VF = 2, VSW = 2, VB = 3;
   localparam int HT = HA + HF + HSW + HB;
   localparam int VT = VA + VF + VSW + VB;
   localparam int LAT = 2;
   localparam logic [14:0] PINS_RST = 15'b0000_0000_0000_1_1_0;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        pix_en = 1'b0;
   logic [3:0]  red = '0, green = '0, blue = '0;
   logic [10:0] pixelX, pixelY;
   logic        sof;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hs, vga_vs, vga_blank_n;

   always #5 clk = ~clk;

   vga_raster_out #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .PIPE_LAT(LAT)
   ) dut (
      .clk(clk), .resetN(resetN), .pix_en(pix_en),
      .Red_level(red), .Green_level(green), .Blue_level(blue),
      .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(sof),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
   );

   typedef struct { int x; int y; bit sof; } coord_exp_t;

   int errors = 0;
   int checks = 0;
   coord_exp_t  crd_q[$];
   logic [14:0] pin_q[$];
   logic [11:0] mux_q[$];
   int mx, my;
   bit const_f = 1'b1;
   int seed;
   bit mon_on = 1'b0;
   bit meas_on = 1'b0;
   int stride = 1;
   int pe_mode = 0;
   bit alt = 1'b0;

   function automatic void chk(string name, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [11:0] colour(int x, int y);
      logic [3:0] r, g, b;
      if (const_f) return 12'hFFF;
      r = x[3:0];
      g = 4'(y * 7 + seed);
      b = 4'(x * y + (seed >> 4));
      return {r, g, b};
   endfunction

   // Pin value the display must show for pixel (x,y), straight from the timing rules.
   function automatic logic [14:0] expect_pins(int x, int y);
      bit vis, hs, vs;
      vis = (x < HA) && (y < VA);
      hs  = !((x >= HA + HF) && (x < HA + HF + HSW));
      vs  = !((y >= VA + VF) && (y < VA + VF + VSW));
      return {vis ? colour(x, y) : 12'h000, hs, vs, vis};
   endfunction

   task automatic sb_restart();
      crd_q.delete();
      pin_q.delete();
      mux_q.delete();
      for (int i = 0; i < LAT + 1; i++) pin_q.push_back(PINS_RST);
      for (int i = 0; i < LAT; i++) mux_q.push_back(12'h000);
      mx = 0;
      my = 0;
   endtask

   task automatic drive_cycle();
      logic [11:0] c;
      @(negedge clk);
      case (pe_mode)
         0:       pix_en = 1'b1;
         1:       begin alt = ~alt; pix_en = alt; end
         default: pix_en = 1'($urandom_range(0, 1));
      endcase
      crd_q.push_back('{mx, my, pix_en && mx == HT - 1 && my == VT - 1});
      if (pix_en) begin
         pin_q.push_back(expect_pins(mx, my));
         mux_q.push_back(colour(int'(pixelX), int'(pixelY)));
         c = mux_q.pop_front();
         {red, green, blue} = c;
         mx++;
         if (mx == HT) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
         end
      end
      mon_on = 1'b1;
   endtask

   // Scoreboard monitor plus pulse-width/period measurement.
   bit prev_en = 1'b0;
   int prev_x, prev_y;
   bit mprim = 1'b0;
   int mcyc;
   bit l_hs, l_vs, l_bl, l_sof;
   bit hsf_seen, vsf_seen, blr_seen, sof_seen;
   int hsf_t, vsf_t, blr_t, sof_t, vis_lines;

   always @(negedge clk) begin
      #1;
      if (mon_on && resetN) begin
         if (crd_q.size() == 0) begin
            chk("coord_queue_underflow", 0, 1);
         end else begin
            coord_exp_t e;
            e = crd_q.pop_front();
            checks++;
            if ({pixelX, pixelY, sof} !== {e.x[10:0], e.y[10:0], e.sof}) begin
               errors++;
               $display("FAIL coord: got x=%0d y=%0d sof=%0b expected x=%0d y=%0d sof=%0b (t=%0t)",
                        pixelX, pixelY, sof, e.x, e.y, e.sof, $time);
            end
         end
         if (pin_q.size() == 0) begin
            chk("pin_queue_underflow", 0, 1);
         end else begin
            checks++;
            if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n} !== pin_q[0]) begin
               errors++;
               $display("FAIL pins: got rgb=%h hs=%0b vs=%0b blank_n=%0b expected rgb=%h hs=%0b vs=%0b blank_n=%0b (t=%0t)",
                        {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_blank_n,
                        pin_q[0][14:3], pin_q[0][2], pin_q[0][1], pin_q[0][0], $time);
            end
            if (pix_en) void'(pin_q.pop_front());
         end
         if (prev_en && prev_x == HT - 1 && prev_y == 10)
            chk("wrap_line10_xy", int'({pixelX, pixelY}), int'({11'd0, 11'd11}));
         if (prev_en && prev_x == HT - 1 && prev_y == VT - 1)
            chk("wrap_frame_xy", int'({pixelX, pixelY}), 0);
         prev_en = pix_en;
         prev_x  = int'(pixelX);
         prev_y  = int'(pixelY);
      end else begin
         prev_en = 1'b0;
      end

      if (mon_on && resetN && meas_on) begin
         if (!mprim) begin
            mprim = 1'b1; mcyc = 0;
            hsf_seen = 0; vsf_seen = 0; blr_seen = 0; sof_seen = 0; vis_lines = 0;
         end else begin
            mcyc++;
            if (l_hs && !vga_hs) begin
               if (hsf_seen) chk("hs_period", mcyc - hsf_t, HT * stride);
               hsf_seen = 1; hsf_t = mcyc;
            end
            if (!l_hs && vga_hs && hsf_seen) chk("hs_width", mcyc - hsf_t, HSW * stride);
            if (l_vs && !vga_vs) begin
               if (vsf_seen) begin
                  chk("vs_period", mcyc - vsf_t, HT * VT * stride);
                  chk("visible_lines", vis_lines, VA);
               end
               vsf_seen = 1; vsf_t = mcyc; vis_lines = 0;
            end
            if (!l_vs && vga_vs && vsf_seen) chk("vs_width", mcyc - vsf_t, HT * VSW * stride);
            if (!l_bl && vga_blank_n) begin
               blr_seen = 1; blr_t = mcyc; vis_lines++;
            end
            if (l_bl && !vga_blank_n && blr_seen) chk("blank_n_width", mcyc - blr_t, HA * stride);
            if (l_sof) chk("sof_width", int'(sof), 0);
            if (sof) begin
               if (sof_seen) chk("sof_period", mcyc - sof_t, HT * VT * stride);
               sof_seen = 1; sof_t = mcyc;
            end
         end
         l_hs = vga_hs; l_vs = vga_vs; l_bl = vga_blank_n; l_sof = sof;
      end else begin
         mprim = 1'b0;
      end
   end

   task automatic check_reset_pins(string tag);
      chk({tag, "_xy"}, int'({pixelX, pixelY}), 0);
      chk({tag, "_sof"}, int'(sof), 0);
      chk({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
      chk({tag, "_hs_vs"}, int'({vga_hs, vga_vs}), 3);
      chk({tag, "_blank_n"}, int'(vga_blank_n), 0);
   endtask

   initial begin
      seed = int'($urandom);
      sb_restart();
      repeat (3) @(negedge clk);
      check_reset_pins("reset");
      resetN = 1'b1;

      // Free-running raster, constant full-white colour: two frames plus slack.
      const_f = 1'b1; pe_mode = 0; stride = 1; meas_on = 1'b1;
      repeat (2 * HT * VT + 3 * HT) drive_cycle();
      meas_on = 1'b0;

      // Half-rate pixel strobe with coordinate-derived colours.
      const_f = 1'b0; pe_mode = 1; stride = 2; alt = 1'b0;
      drive_cycle();
      meas_on = 1'b1;
      repeat (4 * HT * VT + 4 * HT) drive_cycle();
      meas_on = 1'b0;

      // Random strobe, then an asynchronous reset in the middle of a visible line.
      pe_mode = 2;
      repeat (HT * VT) drive_cycle();
      for (int n = 0; n < 20000 && !(mx == 13 && my == 7); n++) drive_cycle();
      chk("reach_reset_point", int'(mx == 13 && my == 7), 1);
      @(negedge clk);
      pix_en = 1'b0;
      mon_on = 1'b0;
      chk("pre_reset_xy", int'({pixelX, pixelY}), int'({11'd13, 11'd7}));
      chk("pre_reset_blank_n", int'(vga_blank_n), 1);
      #2 resetN = 1'b0;
      #1 check_reset_pins("async_reset");
      repeat (2) @(negedge clk);
      sb_restart();
      resetN = 1'b1;

      // Restart: pins must stay blank for the first LAT+1 steps, then track a fresh frame.
      repeat (HT * VT + 2 * HT) drive_cycle();
      pe_mode = 0;
      repeat (HT * VT + 2 * HT) drive_cycle();

      @(negedge clk);
      mon_on = 1'b0;
      pix_en = 1'b0;
      #2;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
